// File: rtl/bopit_pkg.sv
// Shared types and constants for the Bop-It round controller.
package bopit_pkg;

    localparam int CMD_W    = 2;
    localparam int SCORE_W  = 8;
    localparam int NUM_CMDS = 4;
    localparam int RND_W    = 5;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        WAIT,
        HIT,
        OVER
    } state_t;

    // Take the random candidate, but never repeat the previous command
    // once the game has scored at least one round.
    function automatic logic [CMD_W-1:0] next_cmd(
        input logic [CMD_W-1:0] cand,
        input logic [CMD_W-1:0] prev,
        input logic             first_round
    );
        if (!first_round && (cand == prev)) begin
            return cand + CMD_W'(1);
        end
        return cand;
    endfunction

endpackage

// File: rtl/bopit_window_timer.sv
// Response-window countdown: loaded when a command is issued, decremented
// on each qualified tick, flags expiry on the tick that would pass 1.
module bopit_window_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;

    // Countdown register: load has priority over a tick.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expire_o = tick_i && (count_q == W'(1));

endmodule

// File: rtl/bopit_round_ctrl.sv
// Round controller for a Bop-It style game: issues commands, times the
// player's response, scores hits and shrinks the window as levels rise.
module bopit_round_ctrl
    import bopit_pkg::*;
#(
    parameter int INIT_WINDOW = 8,
    parameter int MIN_WINDOW  = 2,
    parameter int LEVEL_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                tick,
    input  logic [RND_W-1:0]    rnd,
    input  logic [NUM_CMDS-1:0] btn,
    output logic [CMD_W-1:0]    cmd,
    output logic                cmd_valid,
    output logic [SCORE_W-1:0]  score,
    output logic                game_over
);

    localparam int WIN_W = $clog2(INIT_WINDOW + 1);

    state_t              state_q;
    logic [CMD_W-1:0]    cmd_q;
    logic                cmd_valid_q;
    logic [SCORE_W-1:0]  score_q;
    logic                game_over_q;
    logic [WIN_W-1:0]    window_q;

    logic [SCORE_W-1:0]  score_d;
    logic [WIN_W-1:0]    window_d;
    logic [NUM_CMDS-1:0] cmd_onehot;
    logic                press;
    logic                press_ok;
    logic                timer_load;
    logic                timer_tick;
    logic                timer_expire;

    // Only the low bits select a command; the rest of the LFSR is unused.
    logic                unused_rnd;
    assign unused_rnd = ^rnd[RND_W-1:CMD_W];

    assign cmd_onehot = NUM_CMDS'(1) << cmd_q;
    assign press      = |btn;
    assign press_ok   = (btn == cmd_onehot);
    assign score_d    = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

    // A press in the same cycle as a tick wins, so the tick is dropped.
    assign timer_load = (state_q == PICK);
    assign timer_tick = (state_q == WAIT) && tick && !press;

    // Window after a hit: shrink by one at each level boundary down to the floor.
    always_comb begin
        // NOTE: assign a default first so no path leaves the output unassigned
        // and a latch is never inferred.
        window_d = window_q;
        if ((score_d != '0) && ((int'(score_d) % LEVEL_STEP) == 0) &&
            (window_q > WIN_W'(MIN_WINDOW))) begin
            window_d = window_q - WIN_W'(1);
        end
    end

    bopit_window_timer #(
        .W (WIN_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (window_q),
        .tick_i     (timer_tick),
        .expire_o   (timer_expire)
    );

    // Game FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            window_q    <= WIN_W'(INIT_WINDOW);
        end else begin
            case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        score_q     <= '0;
                        window_q    <= WIN_W'(INIT_WINDOW);
                        game_over_q <= 1'b0;
                        state_q     <= PICK;
                    end
                end
                PICK: begin
                    cmd_q       <= next_cmd(rnd[CMD_W-1:0], cmd_q, score_q == '0);
                    cmd_valid_q <= 1'b1;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (press) begin
                        cmd_valid_q <= 1'b0;
                        if (press_ok) begin
                            score_q  <= score_d;
                            window_q <= window_d;
                            state_q  <= HIT;
                        end else begin
                            game_over_q <= 1'b1;
                            state_q     <= OVER;
                        end
                    end else if (timer_expire) begin
                        cmd_valid_q <= 1'b0;
                        game_over_q <= 1'b1;
                        state_q     <= OVER;
                    end
                end
                HIT: begin
                    state_q <= PICK;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign score     = score_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_bopit_round_ctrl.sv
// Directed scoreboard bench for bopit_round_ctrl with default parameters.
module tb_bopit_round_ctrl;
    import bopit_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       tick;
    logic [4:0] rnd;
    logic [3:0] btn;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic [7:0] score;
    logic       game_over;

    bopit_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tick      (tick),
        .rnd       (rnd),
        .btn       (btn),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .score     (score),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] cmd;
        logic       valid;
        logic [7:0] score;
        logic       over;
        logic [3:0] win;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model of the visible game state.
    logic [1:0] m_cmd;
    logic       m_valid;
    int         m_score;
    logic       m_over;
    int         m_win;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag   = tag;
        e.cmd   = m_cmd;
        e.valid = m_valid;
        e.score = 8'(m_score);
        e.over  = m_over;
        e.win   = 4'(m_win);
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [15:0] obs;
        logic [15:0] expv;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty: observed size=0 expected size>0");
        end
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            obs  = {cmd, cmd_valid, score, game_over, dut.window_q};
            expv = {e.cmd, e.valid, e.score, e.over, e.win};
            assert (obs === expv) else begin
                bad++;
                $error("FAIL %s: observed cmd=%0d valid=%0b score=%0d over=%0b win=%0d expected cmd=%0d valid=%0b score=%0d over=%0b win=%0d",
                       e.tag, cmd, cmd_valid, score, game_over, dut.window_q,
                       e.cmd, e.valid, e.score, e.over, e.win);
            end
        end
    endtask

    task automatic step(input string tag);
        push_exp(tag);
        cyc();
        pop_check();
    endtask

    task automatic snap(input string tag);
        push_exp(tag);
        pop_check();
    endtask

    task automatic check_idle(input string tag);
        total++;
        assert (dut.state_q === IDLE) else begin
            bad++;
            $error("FAIL %s: observed state=%0d expected state=%0d", tag, dut.state_q, IDLE);
        end
    endtask

    function automatic logic [1:0] model_pick(input logic [4:0] r);
        logic [1:0] cand;
        cand = r[1:0];
        if ((cand == m_cmd) && (m_score != 0)) return cand + 2'd1;
        return cand;
    endfunction

    task automatic model_hit();
        m_score = (m_score == 255) ? 255 : m_score + 1;
        if ((m_score % 4 == 0) && (m_win > 2)) m_win = m_win - 1;
        m_valid = 1'b0;
    endtask

    task automatic model_new_game();
        m_score = 0;
        m_win   = 8;
        m_over  = 1'b0;
        m_valid = 1'b0;
    endtask

    // One full correct round starting in PICK and ending back in PICK.
    task automatic do_round(input logic [4:0] r);
        rnd     = r;
        m_cmd   = model_pick(r);
        m_valid = 1'b1;
        step("round_pick");
        btn = 4'b0001 << m_cmd;
        model_hit();
        step("round_hit");
        btn = 4'b0000;
        step("round_hit_to_pick");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tick = 1'b0; rnd = '0; btn = '0;
        m_cmd = '0; m_valid = 1'b0; m_score = 0; m_over = 1'b0; m_win = 8;
        repeat (2) cyc();
        rst = 1'b0;
        snap("reset_values");
        check_idle("reset_state");

        // Inputs other than start are ignored in IDLE.
        btn = 4'b1111; tick = 1'b1;
        step("idle_ignores_inputs");
        btn = '0; tick = 1'b0;

        // Start, first command from rnd=1f, correct press on 1000.
        start = 1'b1; rnd = 5'h1f;
        model_new_game();
        step("start_to_pick");
        start = 1'b0;
        do_round(5'h1f);
        do_round(5'h01);

        // Repeated candidate bumps to the next command, then a wrong press.
        rnd = 5'h01; m_cmd = model_pick(rnd); m_valid = 1'b1;
        step("pick_repeat_bump");
        btn = 4'b0001; m_over = 1'b1; m_valid = 1'b0;
        step("wrong_btn_over");
        btn = 4'b0100; tick = 1'b1;
        step("over_ignores_inputs");
        btn = '0; tick = 1'b0;

        // Restart from OVER, then the wrap case 3 -> 0.
        start = 1'b1; rnd = 5'h03;
        model_new_game();
        step("restart_from_over");
        start = 1'b0;
        do_round(5'h03);
        rnd = 5'h03; m_cmd = model_pick(rnd); m_valid = 1'b1;
        step("pick_wrap");

        // Timeout on the 8th tick; a stray start in WAIT is ignored.
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            if (i == 8) begin m_over = 1'b1; m_valid = 1'b0; end
            step($sformatf("tick_%0d", i));
            tick = 1'b0;
            if (i < 8) begin
                start = (i == 3);
                step("tick_gap");
                start = 1'b0;
            end
        end

        // Press coinciding with the 8th tick is a hit.
        start = 1'b1; rnd = 5'h00;
        model_new_game();
        step("restart_2");
        start = 1'b0;
        m_cmd = model_pick(rnd); m_valid = 1'b1;
        step("pick_timed");
        for (int i = 1; i <= 7; i++) begin
            tick = 1'b1;
            step($sformatf("run_tick_%0d", i));
        end
        btn = 4'b0001 << m_cmd;
        model_hit();
        step("press_on_last_tick");
        tick = 1'b0; btn = '0;
        step("hit_to_pick_2");

        // Reach score 5, enter WAIT, then abort with an async reset.
        repeat (4) do_round(5'($urandom));
        rnd = 5'($urandom); m_cmd = model_pick(rnd); m_valid = 1'b1;
        step("pick_before_rst");
        rst = 1'b1;
        #1;
        m_cmd = '0; m_valid = 1'b0; m_score = 0; m_over = 1'b0; m_win = 8;
        snap("async_rst_mid_game");
        check_idle("async_rst_state");
        cyc();
        rst = 1'b0;

        // Fresh game: long run through window shrink and score saturation.
        start = 1'b1; rnd = 5'($urandom);
        model_new_game();
        step("fresh_start");
        start = 1'b0;
        for (int i = 0; i < 256; i++) do_round(5'($urandom));
        snap("saturated_score");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
